mem_stage_ctrl: RTL and testbench

Memory-stage controller of the 5-stage MIPS pipeline. It consumes the M-stage control and data bundle from the EX/M pipeline register and drives the data-memory request/acknowledge interface, including halfword (SH/LH) byte-lane steering and sign extension. It holds the pipeline with a stall while memory is busy and registers the result into the WB stage.

---
 rtl/mem_stage_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MIPS M-stage controller: data-memory handshake, halfword lane steering,
// load sign extension, timeout abort and the M/WB pipeline register.
module mem_stage_ctrl #(
    parameter int data_size = 32,
    parameter int pc_size   = 18,
    parameter int addr_size = 16,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 M_MemtoReg,
    input  logic                 M_RegWrite,
    input  logic                 M_MemWrite,
    input  logic                 M_SH,
    input  logic                 M_LH,
    input  logic                 M_to_reg31,
    input  logic [data_size-1:0] M_ALU_result,
    input  logic [data_size-1:0] M_Rt_data,
    input  logic [pc_size-1:0]   M_PCplus8,
    input  logic [4:0]           M_WR_out,
    output logic                 DM_req,
    output logic                 DM_we,
    output logic [addr_size-1:0] DM_addr,
    output logic [3:0]           DM_be,
    output logic [data_size-1:0] DM_wdata,
    input  logic                 DM_ack,
    input  logic [data_size-1:0] DM_rdata,
    output logic                 stall,
    output logic                 WB_RegWrite,
    output logic [4:0]           WB_WR_out,
    output logic [data_size-1:0] WB_WD,
    output logic                 align_err,
    output logic                 bus_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t         state;
    logic [7:0]     cnt;

    logic           access;
    logic           half;
    logic           misaligned;
    logic           at_limit;
    logic           abort;
    logic [15:0]    half_sel;
    logic [data_size-1:0] load_data;
    logic [data_size-1:0] wd_next;
    logic [4:0]     wr_next;

    always_comb begin
        access     = M_MemtoReg | M_MemWrite;
        half       = M_SH | M_LH;
        misaligned = access & (half ? M_ALU_result[0] : (M_ALU_result[1:0] != 2'b00));
        at_limit   = (state == S_WAIT) && (cnt == 8'(TIMEOUT));
    end

    // Request is dropped the moment reset is seen so an in-flight access dies at once.
    always_comb begin
        DM_req = 1'b0;
        if (!rst)
            DM_req = (state == S_WAIT) | (access & ~misaligned);
    end

    // A late ack in the final WAIT cycle still completes; only a silent bus aborts.
    always_comb begin
        stall = DM_req & ~DM_ack & ~at_limit;
        abort = DM_req & ~DM_ack & at_limit;
        DM_we = DM_req & M_MemWrite;
    end

    always_comb begin
        DM_addr = {M_ALU_result[addr_size-1:2], 2'b00};
        DM_be   = 4'b1111;
        if (half)
            DM_be = M_ALU_result[1] ? 4'b1100 : 4'b0011;
        DM_wdata = M_Rt_data;
        if (M_SH)
            DM_wdata[31:0] = {M_Rt_data[15:0], M_Rt_data[15:0]};
    end

    always_comb begin
        half_sel  = M_ALU_result[1] ? DM_rdata[31:16] : DM_rdata[15:0];
        load_data = DM_rdata;
        if (M_LH)
            load_data = {{(data_size-16){half_sel[15]}}, half_sel};
        wr_next = M_to_reg31 ? 5'd31 : M_WR_out;
        if (M_to_reg31)
            wd_next = {{(data_size-pc_size){1'b0}}, M_PCplus8};
        else if (M_MemtoReg)
            wd_next = load_data;
        else
            wd_next = M_ALU_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            WB_RegWrite <= 1'b0;
            WB_WR_out   <= 5'd0;
            WB_WD       <= '0;
            align_err   <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (DM_req && !DM_ack) begin
                        state <= S_WAIT;
                        cnt   <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (DM_ack || at_limit) begin
                        state <= S_IDLE;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 8'd0;
                end
            endcase

            // A held instruction leaves a bubble in WB; error pulses belong to the retiring one.
            if (stall) begin
                WB_RegWrite <= 1'b0;
                align_err   <= 1'b0;
                bus_err     <= 1'b0;
            end else begin
                WB_RegWrite <= M_RegWrite & ~(misaligned | abort);
                WB_WR_out   <= wr_next;
                WB_WD       <= wd_next;
                align_err   <= misaligned;
                bus_err     <= abort;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl against a per-instruction transaction model.
module tb_mem_stage_ctrl;
    localparam int TO = 15;
    localparam int K_ALU = 0, K_LW = 1, K_LH = 2, K_SW = 3, K_SH = 4, K_JAL = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        M_MemtoReg, M_RegWrite, M_MemWrite, M_SH, M_LH, M_to_reg31;
    logic [31:0] M_ALU_result, M_Rt_data;
    logic [17:0] M_PCplus8;
    logic [4:0]  M_WR_out;
    logic        DM_req, DM_we, DM_ack;
    logic [15:0] DM_addr;
    logic [3:0]  DM_be;
    logic [31:0] DM_wdata, DM_rdata;
    logic        stall, WB_RegWrite, align_err, bus_err;
    logic [4:0]  WB_WR_out;
    logic [31:0] WB_WD;

    int nvec = 0;
    int nerr = 0;

    mem_stage_ctrl #(.data_size(32), .pc_size(18), .addr_size(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .M_MemtoReg(M_MemtoReg), .M_RegWrite(M_RegWrite), .M_MemWrite(M_MemWrite),
        .M_SH(M_SH), .M_LH(M_LH), .M_to_reg31(M_to_reg31),
        .M_ALU_result(M_ALU_result), .M_Rt_data(M_Rt_data), .M_PCplus8(M_PCplus8),
        .M_WR_out(M_WR_out),
        .DM_req(DM_req), .DM_we(DM_we), .DM_addr(DM_addr), .DM_be(DM_be),
        .DM_wdata(DM_wdata), .DM_ack(DM_ack), .DM_rdata(DM_rdata),
        .stall(stall), .WB_RegWrite(WB_RegWrite), .WB_WR_out(WB_WR_out),
        .WB_WD(WB_WD), .align_err(align_err), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_instr(input int kind, input logic [31:0] alu, input logic [31:0] rt,
                             input logic [17:0] pc, input logic [4:0] wr);
        M_MemtoReg   = (kind == K_LW) || (kind == K_LH);
        M_MemWrite   = (kind == K_SW) || (kind == K_SH);
        M_SH         = (kind == K_SH);
        M_LH         = (kind == K_LH);
        M_to_reg31   = (kind == K_JAL);
        M_RegWrite   = (kind == K_ALU) || (kind == K_LW) || (kind == K_LH) || (kind == K_JAL);
        M_ALU_result = alu;
        M_Rt_data    = rt;
        M_PCplus8    = pc;
        M_WR_out     = wr;
    endtask

    // Called at posedge+1. lat = cycle index of ack (0 = same cycle), negative = never.
    task automatic run(input int kind, input logic [31:0] alu, input logic [31:0] rt,
                       input logic [17:0] pc, input logic [4:0] wr, input int lat,
                       input logic [31:0] rdata);
        logic ld, st, hf, mis, req, tmo, rw;
        logic [15:0] hv;
        logic [31:0] wd;
        logic [3:0]  be;
        int e;
        set_instr(kind, alu, rt, pc, wr);
        DM_rdata = rdata;
        ld  = (kind == K_LW) || (kind == K_LH);
        st  = (kind == K_SW) || (kind == K_SH);
        hf  = (kind == K_LH) || (kind == K_SH);
        mis = (ld || st) && (hf ? alu[0] : (alu[1:0] != 2'b00));
        req = (ld || st) && !mis;
        tmo = req && (lat < 0 || lat > TO);
        e   = !req ? 0 : (tmo ? TO : lat);
        DM_ack = req ? (lat == 0) : 1'($urandom_range(0, 1));
        be  = hf ? (alu[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        for (int c = 0; c <= e; c++) begin
            #3;
            chk("dm_req", DM_req, req);
            chk("stall", stall, req && (c != e));
            chk("dm_we", DM_we, req && st);
            if (req) begin
                chk("dm_addr", DM_addr, {alu[15:2], 2'b00});
                chk("dm_be", DM_be, be);
                if (st) chk("dm_wdata", DM_wdata, (kind == K_SH) ? {rt[15:0], rt[15:0]} : rt);
            end
            @(posedge clk); #1;
            if (c < e) begin
                chk("bubble_rw", WB_RegWrite, 1'b0);
                chk("bubble_buserr", bus_err, 1'b0);
                DM_ack = (c + 1 == lat);
            end
        end
        hv = alu[1] ? rdata[31:16] : rdata[15:0];
        if (kind == K_JAL)     wd = {14'd0, pc};
        else if (kind == K_LH) wd = {{16{hv[15]}}, hv};
        else if (kind == K_LW) wd = rdata;
        else                   wd = alu;
        rw = ((kind == K_ALU) || ld || (kind == K_JAL)) && !mis && !tmo;
        chk("wb_rw", WB_RegWrite, rw);
        chk("wb_wr", WB_WR_out, (kind == K_JAL) ? 5'd31 : wr);
        chk("wb_wd", WB_WD, wd);
        chk("align_err", align_err, mis);
        chk("bus_err", bus_err, tmo);
    endtask

    initial begin
        int kind, r, lat;
        logic [31:0] alu;
        rst = 1'b1;
        set_instr(K_LW, 32'h10, 32'h0, 18'h0, 5'd1);
        DM_ack = 1'b0;
        DM_rdata = 32'h0;
        @(posedge clk); #1;
        #3;
        chk("rst_req", DM_req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        @(posedge clk); #1;
        chk("rst_wb_rw", WB_RegWrite, 1'b0);
        chk("rst_wb_wr", WB_WR_out, 5'd0);
        chk("rst_wb_wd", WB_WD, 32'h0);
        chk("rst_align", align_err, 1'b0);
        chk("rst_bus", bus_err, 1'b0);
        rst = 1'b0;

        run(K_LW,  32'h0010, 32'h0,        18'h0,   5'd5,  0, 32'h12345678);
        run(K_LH,  32'h0012, 32'h0,        18'h0,   5'd7,  3, 32'h80010000);
        run(K_SH,  32'h0020, 32'hAAAABEEF, 18'h0,   5'd2,  0, 32'h0);
        run(K_LW,  32'h0013, 32'h0,        18'h0,   5'd4,  0, 32'h5555AAAA);
        run(K_LW,  32'h0040, 32'h0,        18'h0,   5'd6, -1, 32'hDEADBEEF);
        run(K_LW,  32'h0044, 32'h0,        18'h0,   5'd8, TO, 32'hCAFEF00D);
        run(K_LH,  32'h0030, 32'h0,        18'h0,   5'd9,  1, 32'h12347FFF);
        run(K_JAL, 32'h0,    32'h0,        18'h108, 5'd3,  0, 32'h0);

        // Reset while a load is waiting on the bus.
        set_instr(K_LW, 32'h48, 32'h0, 18'h0, 5'd10);
        DM_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #3;
        chk("rstw_req", DM_req, 1'b0);
        chk("rstw_stall", stall, 1'b0);
        @(posedge clk); #1;
        chk("rstw_wb_rw", WB_RegWrite, 1'b0);
        chk("rstw_wb_wr", WB_WR_out, 5'd0);
        chk("rstw_wb_wd", WB_WD, 32'h0);
        chk("rstw_bus", bus_err, 1'b0);
        rst = 1'b0;
        run(K_LW, 32'h004C, 32'h0, 18'h0, 5'd11, 2, 32'h0BADF00D);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 5);
            alu  = $urandom;
            if ($urandom_range(0, 3) != 0)
                alu = (kind == K_LH || kind == K_SH) ? (alu & ~32'h1) : (alu & ~32'h3);
            r = $urandom_range(0, 9);
            if (r < 7)       lat = $urandom_range(0, 3);
            else if (r == 7) lat = TO;
            else if (r == 8) lat = -1;
            else             lat = TO + 1;
            run(kind, alu, $urandom, 18'($urandom), 5'($urandom), lat, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
